// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - RV32I IF stage: PC register, ROM address, IF/ID pipeline register
// Optional FETCH_PERF_CNT_EN adds saturating fetched/flushed counters.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h00000000,
  parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic [31:0] imem_addr_o,
  input  logic [31:0] imem_instr_i,
  output logic [31:0] if_id_pc_o,
  output logic [31:0] if_id_pc4_o,
  output logic [31:0] if_id_instr_o,
  output logic        if_id_valid_o,
  output logic        misaligned_o,
  output logic [31:0] fetched_cnt_o,
  output logic [31:0] flushed_cnt_o
);

  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        squash;
  logic        load;

  assign pc_plus4    = pc + 32'd4;
  assign imem_addr_o = pc;
  // A redirect always squashes the wrong-path fetch sitting in IF/ID.
  assign squash      = flush_i | redirect_i;
  assign load        = !squash && !stall_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc           <= RESET_PC;
      misaligned_o <= 1'b0;
    end else begin
      misaligned_o <= redirect_i && (redirect_pc_i[1:0] != 2'b00);
      if (redirect_i)
        pc <= {redirect_pc_i[31:2], 2'b00};
      else if (!stall_i)
        pc <= pc_plus4;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_id_instr_o <= NOP_INSTR;
      if_id_pc_o    <= 32'h0;
      if_id_pc4_o   <= 32'h0;
      if_id_valid_o <= 1'b0;
    end else if (squash) begin
      if_id_instr_o <= NOP_INSTR;
      if_id_pc_o    <= 32'h0;
      if_id_pc4_o   <= 32'h0;
      if_id_valid_o <= 1'b0;
    end else if (!stall_i) begin
      if_id_instr_o <= imem_instr_i;
      if_id_pc_o    <= pc;
      if_id_pc4_o   <= pc_plus4;
      if_id_valid_o <= 1'b1;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetched_cnt;
  logic [31:0] flushed_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetched_cnt <= 32'h0;
      flushed_cnt <= 32'h0;
    end else begin
      if (load && fetched_cnt != 32'hFFFFFFFF)
        fetched_cnt <= fetched_cnt + 32'd1;
      if (squash && if_id_valid_o && flushed_cnt != 32'hFFFFFFFF)
        flushed_cnt <= flushed_cnt + 32'd1;
    end
  end

  assign fetched_cnt_o = fetched_cnt;
  assign flushed_cnt_o = flushed_cnt;
`else
  assign fetched_cnt_o = 32'h0;
  assign flushed_cnt_o = 32'h0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - self-checking bench for fetch_stage against a behavioural model
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall_i, flush_i, redirect_i;
  logic [31:0] redirect_pc_i;
  logic [31:0] imem_addr_o, imem_instr_i;
  logic [31:0] if_id_pc_o, if_id_pc4_o, if_id_instr_o;
  logic        if_id_valid_o, misaligned_o;
  logic [31:0] fetched_cnt_o, flushed_cnt_o;

  int passed = 0;
  int total  = 0;

  // model state
  logic [31:0] m_pc, m_ipc, m_ipc4, m_instr, m_fc, m_flc;
  logic        m_valid, m_mis;

  fetch_stage dut (
    .clk(clk), .rst_n(rst_n), .stall_i(stall_i), .flush_i(flush_i),
    .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .imem_addr_o(imem_addr_o), .imem_instr_i(imem_instr_i),
    .if_id_pc_o(if_id_pc_o), .if_id_pc4_o(if_id_pc4_o),
    .if_id_instr_o(if_id_instr_o), .if_id_valid_o(if_id_valid_o),
    .misaligned_o(misaligned_o), .fetched_cnt_o(fetched_cnt_o),
    .flushed_cnt_o(flushed_cnt_o)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rom(input logic [31:0] a);
    case (a)
      32'h00000000: rom = 32'h00A00093;
      32'h0000001C: rom = 32'h06400A13;
      default:      rom = (a * 32'h01000193) ^ 32'h5BD1E995;
    endcase
  endfunction

  assign imem_instr_i = rom(imem_addr_o);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp)
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    else
      passed++;
  endtask

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFFFFFF) ? v : v + 32'd1;
  endfunction

  task automatic model_reset();
    m_pc = 32'h0; m_ipc = 32'h0; m_ipc4 = 32'h0; m_instr = NOP;
    m_valid = 1'b0; m_mis = 1'b0; m_fc = 32'h0; m_flc = 32'h0;
  endtask

  task automatic model_edge();
    if (!rst_n) begin
      model_reset();
      return;
    end
    if (flush_i || redirect_i) begin
      if (m_valid) m_flc = sat_inc(m_flc);
      m_instr = NOP; m_ipc = 0; m_ipc4 = 0; m_valid = 0;
    end else if (!stall_i) begin
      m_instr = rom(m_pc); m_ipc = m_pc; m_ipc4 = m_pc + 4; m_valid = 1;
      m_fc = sat_inc(m_fc);
    end
    m_mis = redirect_i && (redirect_pc_i % 4 != 0);
    if (redirect_i)    m_pc = redirect_pc_i - (redirect_pc_i % 4);
    else if (!stall_i) m_pc = m_pc + 4;
  endtask

  task automatic compare_all(input string ph);
    check({ph, ":addr"},  imem_addr_o,   m_pc);
    check({ph, ":pc"},    if_id_pc_o,    m_ipc);
    check({ph, ":pc4"},   if_id_pc4_o,   m_ipc4);
    check({ph, ":instr"}, if_id_instr_o, m_instr);
    check({ph, ":valid"}, {31'b0, if_id_valid_o}, {31'b0, m_valid});
    check({ph, ":mis"},   {31'b0, misaligned_o},  {31'b0, m_mis});
`ifdef FETCH_PERF_CNT_EN
    check({ph, ":fcnt"},  fetched_cnt_o, m_fc);
    check({ph, ":flcnt"}, flushed_cnt_o, m_flc);
`else
    check({ph, ":fcnt"},  fetched_cnt_o, 32'h0);
    check({ph, ":flcnt"}, flushed_cnt_o, 32'h0);
`endif
  endtask

  task automatic cycle(input string ph);
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_all(ph);
  endtask

  task automatic idle_inputs();
    stall_i = 0; flush_i = 0; redirect_i = 0; redirect_pc_i = 0;
  endtask

  initial begin
    rst_n = 0;
    idle_inputs();
    model_reset();
    repeat (2) @(negedge clk);
    compare_all("reset");
    rst_n = 1;
    check("rel_addr0", imem_addr_o, 32'h0);

    cycle("first");
    check("first_instr", if_id_instr_o, 32'h00A00093);
    check("first_pc4", if_id_pc4_o, 32'h4);
    cycle("second");
    check("second_addr", imem_addr_o, 32'h8);

    stall_i = 1;
    cycle("stall1");
    cycle("stall2");
    check("stall_addr", imem_addr_o, 32'h8);
    check("stall_ifpc", if_id_pc_o, 32'h4);
    stall_i = 0;
    cycle("unstall");
    check("unstall_instr", if_id_instr_o, rom(32'h8));

    repeat (3) cycle("run");
    check("pre_br_addr", imem_addr_o, 32'h18);
    redirect_i = 1; redirect_pc_i = 32'h1C;
    cycle("br");
    check("br_valid", {31'b0, if_id_valid_o}, 32'h0);
    idle_inputs();
    cycle("br_tgt");
    check("br_tgt_instr", if_id_instr_o, 32'h06400A13);
    check("br_tgt_pc", if_id_pc_o, 32'h1C);

    redirect_i = 1; stall_i = 1; redirect_pc_i = 32'h40;
    cycle("br_stall");
    check("br_stall_addr", imem_addr_o, 32'h40);
    idle_inputs();
    cycle("run");

    redirect_i = 1; redirect_pc_i = 32'h1E;
    cycle("mis");
    check("mis_pulse", {31'b0, misaligned_o}, 32'h1);
    idle_inputs();
    cycle("mis_after");
    check("mis_clear", {31'b0, misaligned_o}, 32'h0);

    redirect_i = 1; redirect_pc_i = 32'hFFFFFFFC;
    cycle("wrap_br");
    idle_inputs();
    cycle("wrap1");
    check("wrap_ifpc", if_id_pc_o, 32'hFFFFFFFC);
    check("wrap_pc4", if_id_pc4_o, 32'h0);
    check("wrap_addr", imem_addr_o, 32'h0);
    cycle("wrap2");

    for (int i = 0; i < 400; i++) begin
      stall_i       = ($urandom_range(0, 3) == 0);
      flush_i       = ($urandom_range(0, 6) == 0);
      redirect_i    = ($urandom_range(0, 9) == 0);
      redirect_pc_i = $urandom;
      cycle("rand");
    end
    idle_inputs();
    repeat (3) cycle("run");

    @(posedge clk);
    model_edge();
    #2;
    rst_n = 0;
    #1;
    model_reset();
    compare_all("async_rst");
    @(negedge clk);
    compare_all("rst_hold");
    rst_n = 1;
    repeat (4) cycle("post_rst");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
